// File: rtl/fwd_select_ctrl_pkg.sv
// Shared definitions for the EX-stage operand-forwarding controller.
// Mux select encodings and the default register-index width.
package fwd_select_ctrl_pkg;

  localparam int DEF_REG_ADDR_W = 4;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

endpackage

// File: rtl/fwd_select_ctrl_if.sv
// Decode-side request and forwarding-control response bundle.
// master = decode/pipeline side, slave = fwd_select_ctrl.
interface fwd_select_ctrl_if #(
  parameter int REG_ADDR_W = 4
);
  logic                  dec_valid;
  logic [REG_ADDR_W-1:0] dec_rs;
  logic [REG_ADDR_W-1:0] dec_rt;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_regwrite;
  logic                  dec_memread;
  logic                  flush;
  logic [1:0]            fwd_sel_a;
  logic [1:0]            fwd_sel_b;
  logic                  stall;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_we;

  modport master (
    output dec_valid, dec_rs, dec_rt, dec_rd, dec_regwrite, dec_memread, flush,
    input  fwd_sel_a, fwd_sel_b, stall, wb_rd, wb_we
  );

  modport slave (
    input  dec_valid, dec_rs, dec_rt, dec_rd, dec_regwrite, dec_memread, flush,
    output fwd_sel_a, fwd_sel_b, stall, wb_rd, wb_we
  );
endinterface

// File: rtl/fwd_select_ctrl_stage.sv
// One pipeline stage's hazard-tracking state (valid, rd, regwrite, memread).
// A bubble clears valid only; the remaining fields are don't-care while invalid.
module fwd_stage_reg #(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubble,
  input  logic                  nxt_valid,
  input  logic [REG_ADDR_W-1:0] nxt_rd,
  input  logic                  nxt_regwrite,
  input  logic                  nxt_memread,
  output logic                  valid,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  regwrite,
  output logic                  memread
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= 1'b0;
      rd       <= '0;
      regwrite <= 1'b0;
      memread  <= 1'b0;
    end else begin
      valid    <= nxt_valid & ~bubble;
      rd       <= nxt_rd;
      regwrite <= nxt_regwrite;
      memread  <= nxt_memread;
    end
  end

endmodule

// File: rtl/fwd_select_ctrl.sv
// Forwarding-select and load-use stall generator for the EX operand muxes.
// Selects are registered (valid while the instruction sits in EX); stall is combinational.
module fwd_select_ctrl
  import fwd_select_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input logic              clk,
  input logic              rst,
  fwd_select_ctrl_if.slave bus
);

  logic                  ex_valid, ex_regwrite, ex_memread;
  logic                  mem_valid, mem_regwrite, mem_memread;
  logic                  wb_valid, wb_regwrite, wb_memread;
  logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
  logic                  ex_wr, mem_wr, wb_wr;
  logic                  stall, ex_bubble;
  logic [1:0]            sel_a, sel_b, nxt_sel_a, nxt_sel_b;

  fwd_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_ex (
    .clk(clk), .rst(rst), .bubble(ex_bubble),
    .nxt_valid(bus.dec_valid), .nxt_rd(bus.dec_rd),
    .nxt_regwrite(bus.dec_regwrite), .nxt_memread(bus.dec_memread),
    .valid(ex_valid), .rd(ex_rd), .regwrite(ex_regwrite), .memread(ex_memread)
  );

  fwd_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_mem (
    .clk(clk), .rst(rst), .bubble(1'b0),
    .nxt_valid(ex_valid), .nxt_rd(ex_rd),
    .nxt_regwrite(ex_regwrite), .nxt_memread(ex_memread),
    .valid(mem_valid), .rd(mem_rd), .regwrite(mem_regwrite), .memread(mem_memread)
  );

  fwd_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_wb (
    .clk(clk), .rst(rst), .bubble(1'b0),
    .nxt_valid(mem_valid), .nxt_rd(mem_rd),
    .nxt_regwrite(mem_regwrite), .nxt_memread(mem_memread),
    .valid(wb_valid), .rd(wb_rd), .regwrite(wb_regwrite), .memread(wb_memread)
  );

  assign ex_wr  = ex_valid  & ex_regwrite  & (ex_rd  != '0);
  assign mem_wr = mem_valid & mem_regwrite & (mem_rd != '0);
  assign wb_wr  = wb_valid  & wb_regwrite  & (wb_rd  != '0);

  // A load in EX cannot feed the 01 path, so any consumer of it waits one cycle.
  assign stall = bus.dec_valid & ex_wr & ex_memread &
                 ((bus.dec_rs == ex_rd) | (bus.dec_rt == ex_rd));

  assign ex_bubble = stall | bus.flush;

  function automatic logic [1:0] pick_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] ex_dst,
    input logic                  ex_w,
    input logic [REG_ADDR_W-1:0] mem_dst,
    input logic                  mem_w
  );
    if (src == '0)                       return SEL_RF;
    else if (ex_w && src == ex_dst)      return SEL_EXMEM;
    else if (mem_w && src == mem_dst)    return SEL_MEMWB;
    else                                 return SEL_RF;
  endfunction

  always_comb begin
    nxt_sel_a = SEL_RF;
    nxt_sel_b = SEL_RF;
    if (bus.dec_valid && !ex_bubble) begin
      nxt_sel_a = pick_sel(bus.dec_rs, ex_rd, ex_wr, mem_rd, mem_wr);
      nxt_sel_b = pick_sel(bus.dec_rt, ex_rd, ex_wr, mem_rd, mem_wr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_a <= SEL_RF;
      sel_b <= SEL_RF;
    end else begin
      sel_a <= nxt_sel_a;
      sel_b <= nxt_sel_b;
    end
  end

  assign bus.fwd_sel_a = sel_a;
  assign bus.fwd_sel_b = sel_b;
  assign bus.stall     = stall;
  assign bus.wb_rd     = wb_rd;
  assign bus.wb_we     = wb_wr;

  logic unused_ok;
  assign unused_ok = mem_memread ^ wb_memread;

endmodule
